// File: rtl/msg_mod_pkg.sv
// rtl/msg_mod_pkg.sv - state encoding and sizing helpers for the frame serializer
// MSG_PARITY_EN selects whether frames carry a trailing even-parity bit.
package msg_mod_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_GAP  = 2'd2
    } state_t;

`ifdef MSG_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) result++;
        return result;
    endfunction

    function automatic int frame_w(input int hdr_w, input int msg_w, input bit par);
        return hdr_w + msg_w + (par ? 1 : 0);
    endfunction

endpackage

// File: rtl/mod_counter.sv
// rtl/mod_counter.sv - modulo-MOD up counter with enable, sync clear and carry-out
module mod_counter
    import msg_mod_pkg::*;
#(
    parameter int MOD = 4,
    parameter int CW  = (clog2(MOD) < 1) ? 1 : clog2(MOD)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          clr,
    output logic [CW-1:0] count,
    output logic          carry
);

    localparam logic [CW-1:0] LAST = CW'(MOD - 1);

    // Clear wins, so a clearing cycle never reports a terminal count.
    assign carry = en & ~clr & (count == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr || carry) begin
            count <= '0;
        end else if (en) begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/msg_frame_serializer.sv
// rtl/msg_frame_serializer.sv - streams {HDR, msg} MSB-first, SAMPLES_PER_BIT clocks per bit
// MSG_PARITY_EN appends an even-parity bit after the payload.
module msg_frame_serializer
    import msg_mod_pkg::*;
#(
    parameter int                MSG_W           = 5,
    parameter int                HDR_W           = 4,
    parameter logic [HDR_W-1:0]  HDR             = 4'b0101,
    parameter int                SAMPLES_PER_BIT = 1024,
    parameter int                GAP_CYC         = 0,
    localparam int               FRAME_W         = frame_w(HDR_W, MSG_W, PAR_EN),
    localparam int               IDX_W           = clog2(FRAME_W + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             send,
    input  logic [MSG_W-1:0] msg,
    input  logic             abort,
    output logic             ready,
    output logic             msg_bit,
    output logic             valid,
    output logic             bit_strobe,
    output logic [IDX_W-1:0] bit_idx,
    output logic             frame_done
);

    localparam int SCNT_W = (clog2(SAMPLES_PER_BIT) < 1) ? 1 : clog2(SAMPLES_PER_BIT);
    localparam int BCNT_W = (clog2(FRAME_W) < 1) ? 1 : clog2(FRAME_W);

    state_t             state;
    state_t             state_nxt;
    logic [FRAME_W-1:0] shreg;
    logic [FRAME_W-1:0] frame_load;
    logic [SCNT_W-1:0]  samp_cnt;
    logic               samp_carry;
    logic [BCNT_W-1:0]  bit_cnt;
    logic               bit_carry;
    logic               gap_carry;
    logic               load;
    logic               cnt_clr;
    logic               last_sample;

`ifdef MSG_PARITY_EN
    assign frame_load = {HDR, msg, ^msg};
`else
    assign frame_load = {HDR, msg};
`endif

    always_comb begin
        state_nxt   = state;
        load        = 1'b0;
        cnt_clr     = 1'b0;
        last_sample = 1'b0;
        ready       = 1'b0;
        valid       = 1'b0;
        unique case (state)
            S_IDLE: begin
                ready = 1'b1;
                if (send) begin
                    load      = 1'b1;
                    cnt_clr   = 1'b1;
                    state_nxt = S_SEND;
                end
            end
            S_SEND: begin
                valid = 1'b1;
                if (abort) begin
                    cnt_clr   = 1'b1;
                    state_nxt = S_IDLE;
                end else if (bit_carry) begin
                    last_sample = 1'b1;
                    state_nxt   = (GAP_CYC > 0) ? S_GAP : S_IDLE;
                end
            end
            S_GAP: begin
                if (abort) begin
                    cnt_clr   = 1'b1;
                    state_nxt = S_IDLE;
                end else if (gap_carry) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            shreg      <= '0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            frame_done <= last_sample;
            if (load) begin
                shreg <= frame_load;
            end else if (cnt_clr) begin
                shreg <= '0;
            end else if (samp_carry) begin
                shreg <= {shreg[FRAME_W-2:0], 1'b0};
            end
        end
    end

    mod_counter #(.MOD(SAMPLES_PER_BIT), .CW(SCNT_W)) u_samp_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (state == S_SEND),
        .clr   (cnt_clr),
        .count (samp_cnt),
        .carry (samp_carry)
    );

    // Advances once per bit; its carry marks the final sample of the frame.
    mod_counter #(.MOD(FRAME_W), .CW(BCNT_W)) u_bit_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (samp_carry),
        .clr   (cnt_clr),
        .count (bit_cnt),
        .carry (bit_carry)
    );

    generate
        if (GAP_CYC > 0) begin : g_gap
            localparam int GCNT_W = (clog2(GAP_CYC) < 1) ? 1 : clog2(GAP_CYC);
            logic [GCNT_W-1:0] gap_cnt_unused;

            mod_counter #(.MOD(GAP_CYC), .CW(GCNT_W)) u_gap_cnt (
                .clk   (clk),
                .rst_n (rst_n),
                .en    (state == S_GAP),
                .clr   (cnt_clr),
                .count (gap_cnt_unused),
                .carry (gap_carry)
            );
        end else begin : g_no_gap
            assign gap_carry = 1'b0;
        end
    endgenerate

    assign msg_bit    = valid & shreg[FRAME_W-1];
    assign bit_strobe = (state == S_SEND) && (samp_cnt == '0);
    assign bit_idx    = IDX_W'(bit_cnt);

endmodule

// File: tb/tb_msg_frame_serializer.sv
// tb/tb_msg_frame_serializer.sv - scoreboard bench for msg_frame_serializer (honours MSG_PARITY_EN)
module tb_msg_frame_serializer;

    localparam int SPB = 4;
`ifdef MSG_PARITY_EN
    localparam int FW = 10;
`else
    localparam int FW = 9;
`endif
    localparam int IW = $clog2(FW + 1);

    typedef struct {
        logic b;
        int   idx;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          send = 1'b0;
    logic          abort = 1'b0;
    logic [4:0]    msg = '0;
    logic          ready, msg_bit, valid, bit_strobe, frame_done;
    logic [IW-1:0] bit_idx;

    logic          g_send = 1'b0;
    logic          g_abort = 1'b0;
    logic [4:0]    g_msg = '0;
    logic          g_ready, g_msg_bit, g_valid, g_bit_strobe, g_frame_done;
    logic [IW-1:0] g_bit_idx;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    exp_t mon_e;
    int   valid_cnt = 0;
    int   strobe_cnt = 0;
    int   done_cnt = 0;
    logic cur_bit = 1'b0;
    logic last_bit = 1'b0;

    always #5 clk = ~clk;

    msg_frame_serializer #(.SAMPLES_PER_BIT(SPB), .GAP_CYC(0)) dut (
        .clk(clk), .rst_n(rst_n), .send(send), .msg(msg), .abort(abort),
        .ready(ready), .msg_bit(msg_bit), .valid(valid), .bit_strobe(bit_strobe),
        .bit_idx(bit_idx), .frame_done(frame_done)
    );

    msg_frame_serializer #(.SAMPLES_PER_BIT(SPB), .GAP_CYC(3)) dut_gap (
        .clk(clk), .rst_n(rst_n), .send(g_send), .msg(g_msg), .abort(g_abort),
        .ready(g_ready), .msg_bit(g_msg_bit), .valid(g_valid), .bit_strobe(g_bit_strobe),
        .bit_idx(g_bit_idx), .frame_done(g_frame_done)
    );

    always @(negedge clk) begin
        if (rst_n) begin
            if (valid) begin
                valid_cnt++;
                checks++;
                if (bit_strobe) begin
                    strobe_cnt++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_bit got bit %0b idx %0d, expected no bit", msg_bit, bit_idx);
                    end else begin
                        mon_e = exp_q.pop_front();
                        if (msg_bit !== mon_e.b || bit_idx !== IW'(mon_e.idx)) begin
                            errors++;
                            $display("FAIL frame_bit got bit %0b idx %0d, expected bit %0b idx %0d",
                                     msg_bit, bit_idx, mon_e.b, mon_e.idx);
                        end
                    end
                    cur_bit  = msg_bit;
                    last_bit = msg_bit;
                end else if (msg_bit !== cur_bit) begin
                    errors++;
                    $display("FAIL bit_hold got %0b, expected %0b", msg_bit, cur_bit);
                end
            end
            if (frame_done) done_cnt++;
        end
    end

    task automatic push_frame(input logic [4:0] m);
        logic [3:0]    h;
        logic [FW-1:0] f;
        h = 4'b0101;
`ifdef MSG_PARITY_EN
        f = {h, m, ^m};
`else
        f = {h, m};
`endif
        for (int i = 0; i < FW; i++) exp_q.push_back('{f[FW-1-i], i});
    endtask

    task automatic reset_counts();
        valid_cnt  = 0;
        strobe_cnt = 0;
        done_cnt   = 0;
    endtask

    task automatic do_send(input logic [4:0] m);
        @(posedge clk); #1;
        send = 1'b1;
        msg  = m;
        push_frame(m);
        @(posedge clk); #1;
        send = 1'b0;
    endtask

    task automatic wait_done(input int target, input string name);
        int n;
        n = 0;
        while (done_cnt < target && n < 200) begin
            @(negedge clk); #1;
            n++;
        end
        checks++;
        if (done_cnt < target) begin
            errors++;
            $display("FAIL %s_timeout got done %0d, expected %0d", name, done_cnt, target);
        end
    endtask

    task automatic check_frame_stats(input int frames, input string name);
        checks++;
        if (valid_cnt !== frames * FW * SPB || strobe_cnt !== frames * FW || done_cnt !== frames) begin
            errors++;
            $display("FAIL %s_stats got valid %0d strobes %0d done %0d, expected %0d %0d %0d",
                     name, valid_cnt, strobe_cnt, done_cnt, frames * FW * SPB, frames * FW, frames);
        end
        checks++;
        if (exp_q.size() !== 0 || ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_end got left %0d ready %0b, expected 0 1", name, exp_q.size(), ready);
        end
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (ready !== 1'b1 || valid !== 1'b0 || msg_bit !== 1'b0 || bit_strobe !== 1'b0 ||
            frame_done !== 1'b0 || bit_idx !== '0 || g_ready !== 1'b1 || g_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got rdy %0b v %0b b %0b s %0b d %0b idx %0d grdy %0b, expected 1 0 0 0 0 0 1",
                     ready, valid, msg_bit, bit_strobe, frame_done, bit_idx, g_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        reset_counts();
        do_send(5'b10011);
        wait_done(1, "single");
        check_frame_stats(1, "single");
    endtask

    task automatic test_back_to_back();
        int n;
        reset_counts();
        @(posedge clk); #1;
        send = 1'b1;
        msg  = 5'b11001;
        push_frame(5'b11001);
        @(posedge clk); #1;
        msg = 5'b00110;
        push_frame(5'b00110);
        n = 0;
        while (frame_done !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (frame_done !== 1'b1 || valid !== 1'b0 || ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_idle_cycle got done %0b valid %0b ready %0b, expected 1 0 1", frame_done, valid, ready);
        end
        @(posedge clk); #1;
        send = 1'b0;
        @(negedge clk);
        checks++;
        if (valid !== 1'b1 || bit_strobe !== 1'b1 || bit_idx !== '0) begin
            errors++;
            $display("FAIL b2b_restart got valid %0b strobe %0b idx %0d, expected 1 1 0", valid, bit_strobe, bit_idx);
        end
        wait_done(2, "b2b");
        check_frame_stats(2, "b2b");
    endtask

    task automatic test_abort();
        int n;
        reset_counts();
        do_send(5'b10110);
        n = 0;
        while (!(valid === 1'b1 && bit_strobe === 1'b1 && bit_idx === IW'(3)) && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 200) begin
            errors++;
            $display("FAIL abort_reach got idx %0d, expected 3", bit_idx);
        end
        @(posedge clk);
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        checks++;
        if (valid !== 1'b0 || ready !== 1'b1 || bit_idx !== '0 || bit_strobe !== 1'b0) begin
            errors++;
            $display("FAIL abort_exit got valid %0b ready %0b idx %0d strobe %0b, expected 0 1 0 0",
                     valid, ready, bit_idx, bit_strobe);
        end
        exp_q.delete();
        repeat (20) @(negedge clk);
        #1;
        checks++;
        if (done_cnt !== 0) begin
            errors++;
            $display("FAIL abort_no_done got %0d, expected 0", done_cnt);
        end
        reset_counts();
        @(posedge clk); #1;
        send  = 1'b1;
        abort = 1'b1;
        msg   = 5'b01101;
        push_frame(5'b01101);
        @(posedge clk); #1;
        send  = 1'b0;
        abort = 1'b0;
        checks++;
        if (valid !== 1'b1) begin
            errors++;
            $display("FAIL abort_send_wins got valid %0b, expected 1", valid);
        end
        wait_done(1, "after_abort");
        check_frame_stats(1, "after_abort");
    endtask

    task automatic test_reset_mid();
        int n;
        reset_counts();
        do_send(5'b11100);
        n = 0;
        while (!(valid === 1'b1 && bit_strobe === 1'b1 && bit_idx === IW'(6)) && n < 200) begin
            @(negedge clk);
            n++;
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (n >= 200 || valid !== 1'b0 || ready !== 1'b1 || msg_bit !== 1'b0 || bit_strobe !== 1'b0 ||
            bit_idx !== '0 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got valid %0b ready %0b bit %0b strobe %0b idx %0d done %0b, expected 0 1 0 0 0 0",
                     valid, ready, msg_bit, bit_strobe, bit_idx, frame_done);
        end
        exp_q.delete();
        repeat (2) @(negedge clk);
        @(posedge clk); #2;
        rst_n = 1'b1;
        reset_counts();
        repeat (20) @(negedge clk);
        #1;
        checks++;
        if (valid_cnt !== 0 || done_cnt !== 0 || ready !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_idle got valid %0d done %0d ready %0b, expected 0 0 1", valid_cnt, done_cnt, ready);
        end
    endtask

    task automatic test_gap();
        int n, vcnt, gcnt, vbad;
        @(posedge clk); #1;
        g_send = 1'b1;
        g_msg  = 5'b10011;
        @(posedge clk); #1;
        g_send = 1'b0;
        n = 0;
        vcnt = 0;
        while (g_frame_done !== 1'b1 && n < 200) begin
            @(negedge clk);
            if (g_valid === 1'b1) vcnt++;
            n++;
        end
        checks++;
        if (g_frame_done !== 1'b1 || vcnt !== FW * SPB || g_valid !== 1'b0 || g_ready !== 1'b0) begin
            errors++;
            $display("FAIL gap_frame got done %0b valid_cycles %0d valid %0b ready %0b, expected 1 %0d 0 0",
                     g_frame_done, vcnt, g_valid, g_ready, FW * SPB);
        end
        gcnt = 1;
        vbad = 0;
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            n++;
            if (g_ready === 1'b1) break;
            if (g_valid !== 1'b0) vbad++;
            gcnt++;
        end
        checks++;
        if (gcnt !== 3 || vbad !== 0) begin
            errors++;
            $display("FAIL gap_length got gap %0d valid_in_gap %0d, expected 3 0", gcnt, vbad);
        end
    endtask

`ifdef MSG_PARITY_EN
    task automatic test_parity();
        reset_counts();
        do_send(5'b10110);
        wait_done(1, "parity1");
        check_frame_stats(1, "parity1");
        checks++;
        if (last_bit !== 1'b1) begin
            errors++;
            $display("FAIL parity_odd got %0b, expected 1", last_bit);
        end
        reset_counts();
        do_send(5'b10010);
        wait_done(1, "parity0");
        check_frame_stats(1, "parity0");
        checks++;
        if (last_bit !== 1'b0) begin
            errors++;
            $display("FAIL parity_even got %0b, expected 0", last_bit);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        test_gap();
`ifdef MSG_PARITY_EN
        test_parity();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
